// File: rtl/vga_out_pkg.sv
// Shared types and constants for the VGA output stage.
package vga_out_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RUN       = 2'd1,
    MUTED     = 2'd2
  } vga_state_t;

  localparam int PIPE_DEPTH_DEF = 2;
  localparam int PIPE_DEPTH_MAX = 4;
  localparam int PIPE_WIDTH     = 5;  // {hsync, vsync, rgb[2:0]}

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-latency register pipeline with asynchronous reset to a chosen level.
module vga_delay_line #(
  parameter int              WIDTH     = 5,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the input through DEPTH registers; reset forces every stage inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_out_stage.sv
// Final video output stage: frame-synchronous mute FSM, colour gating,
// aligned sync/colour delay and a free-running frame counter.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   SYNC_WAIT | after reset, no frame start seen yet; sync passes, video black
//   RUN       | video enabled; visible pixels forwarded
//   MUTED     | video blanked on request; sync keeps running
module vga_out_stage
  import vga_out_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter bit OUT_INVERT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        display_on_i,
  input  logic [2:0]  rgb_i,
  input  logic        mute_req,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  rgb,
  output logic [15:0] frame_cnt,
  output logic        out_valid
);

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("vga_out_stage: PIPE_DEPTH out of range 1..4");
  end

  localparam logic [PIPE_WIDTH-1:0] PIPE_IDLE = {OUT_INVERT, OUT_INVERT, 3'b000};

  vga_state_t            state_q, state_d;
  logic                  vsync_prev_q;
  logic                  frame_start;
  logic                  out_valid_q;
  logic [15:0]           cnt_q;
  logic [2:0]            rgb_gated;
  logic [PIPE_WIDTH-1:0] pipe_d, pipe_q;

  // History resets high so a vsync already high at release is not a frame start.
  assign frame_start = vsync_i & ~vsync_prev_q;

  // Next state: transitions happen only on a frame start, so mute never tears a frame.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      case (state_q)
        SYNC_WAIT: state_d = mute_req ? MUTED : RUN;
        RUN:       if (mute_req)  state_d = MUTED;
        MUTED:     if (!mute_req) state_d = RUN;
        default:   state_d = SYNC_WAIT;
      endcase
    end
  end

  // State register, valid flag decoded alongside it, vsync history and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SYNC_WAIT;
      out_valid_q  <= 1'b0;
      vsync_prev_q <= 1'b1;
      cnt_q        <= 16'h0000;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= (state_d == RUN);
      vsync_prev_q <= vsync_i;
      // Written every cycle; the add wraps naturally from FFFF to 0000.
      cnt_q        <= cnt_q + {15'd0, frame_start};
    end
  end

  // Colour gate uses the state before this cycle's update.
  always_comb begin
    rgb_gated = 3'b000;
    if (state_q == RUN && display_on_i) rgb_gated = rgb_i;
  end

  // Polarity is applied before the pipeline so the reset level equals the idle level.
  assign pipe_d = {hsync_i ^ OUT_INVERT, vsync_i ^ OUT_INVERT, rgb_gated};

  vga_delay_line #(
    .WIDTH     (PIPE_WIDTH),
    .DEPTH     (PIPE_DEPTH),
    .RESET_VAL (PIPE_IDLE)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  assign hsync     = pipe_q[4];
  assign vsync     = pipe_q[3];
  assign rgb       = pipe_q[2:0];
  assign frame_cnt = cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Scoreboard bench for vga_out_stage: default instance (depth 2, normal polarity)
// and a second instance (depth 4, inverted sync) driven by the same stimulus.
module tb_vga_out_stage;
  import vga_out_pkg::*;

  localparam int K_HS = 0, K_VS = 1, K_RGB = 2, K_OV = 3, K_FC = 4;

  typedef struct {
    int          due;
    int          sel;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_i, vsync_i, display_on_i, mute_req;
  logic [2:0]  rgb_i;
  logic        hs0, vs0, ov0, hs1, vs1, ov1;
  logic [2:0]  rgb0, rgb1;
  logic [15:0] fc0, fc1;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  vga_out_stage dut0 (
    .clk(clk), .reset(reset), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .display_on_i(display_on_i), .rgb_i(rgb_i), .mute_req(mute_req),
    .hsync(hs0), .vsync(vs0), .rgb(rgb0), .frame_cnt(fc0), .out_valid(ov0)
  );

  vga_out_stage #(.PIPE_DEPTH(4), .OUT_INVERT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .display_on_i(display_on_i), .rgb_i(rgb_i), .mute_req(mute_req),
    .hsync(hs1), .vsync(vs1), .rgb(rgb1), .frame_cnt(fc1), .out_valid(ov1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] actual(input int sel, input int kind);
    logic [15:0] r;
    r = '0;
    case (kind)
      K_HS:    r = {15'd0, (sel != 0) ? hs1 : hs0};
      K_VS:    r = {15'd0, (sel != 0) ? vs1 : vs0};
      K_RGB:   r = {13'd0, (sel != 0) ? rgb1 : rgb0};
      K_OV:    r = {15'd0, (sel != 0) ? ov1 : ov0};
      default: r = (sel != 0) ? fc1 : fc0;
    endcase
    return r;
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_HS:    return "hsync";
      K_VS:    return "vsync";
      K_RGB:   return "rgb";
      K_OV:    return "out_valid";
      default: return "frame_cnt";
    endcase
  endfunction

  // Monitor: compare every expectation that falls due at this sample point.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        chk($sformatf("dut%0d_%s_c%0d", sbq[i].sel, kname(sbq[i].kind), cyc),
            actual(sbq[i].sel, sbq[i].kind), sbq[i].val);
        sbq.delete(i);
      end
    end
  end

  task automatic expect_at(input int sel, input int kind, input int lat, input logic [15:0] v);
    exp_t e;
    e.due  = cyc + lat;
    e.sel  = sel;
    e.kind = kind;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic step(input logic hs, input logic vs, input logic de,
                      input logic [2:0] c, input logic m);
    @(negedge clk);
    hsync_i      = hs;
    vsync_i      = vs;
    display_on_i = de;
    rgb_i        = c;
    mute_req     = m;
  endtask

  // Sync for both instances: depth 2 straight, depth 4 inverted.
  task automatic exp_sync(input logic hs, input logic vs);
    expect_at(0, K_HS, 2, {15'd0, hs});
    expect_at(0, K_VS, 2, {15'd0, vs});
    expect_at(1, K_HS, 4, {15'd0, ~hs});
    expect_at(1, K_VS, 4, {15'd0, ~vs});
  endtask

  task automatic exp_state(input logic ov, input logic [15:0] fc);
    expect_at(0, K_OV, 1, {15'd0, ov});
    expect_at(0, K_FC, 1, fc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    hsync_i = 1'b0; vsync_i = 1'b0; display_on_i = 1'b0; rgb_i = 3'b000; mute_req = 1'b0;
    repeat (2) @(negedge clk);
    hsync_i = 1'b1; vsync_i = 1'b1; display_on_i = 1'b1; rgb_i = 3'b111;
    repeat (2) @(negedge clk);
    chk("reset_rgb0", {13'd0, rgb0}, 16'h0);
    chk("reset_hs0",  {15'd0, hs0},  16'h0);
    chk("reset_vs0",  {15'd0, vs0},  16'h0);
    chk("reset_ov0",  {15'd0, ov0},  16'h0);
    chk("reset_fc0",  fc0,           16'h0);
    chk("reset_hs1",  {15'd0, hs1},  16'h1);
    chk("reset_vs1",  {15'd0, vs1},  16'h1);

    step(1'b0, 1'b0, 1'b1, 3'b101, 1'b0);
    reset = 1'b1;

    // Sync passes while waiting for the first frame; video stays black.
    for (int i = 0; i < 8; i++) begin
      logic hs;
      hs = ((i % 4) >= 2);
      step(hs, 1'b0, 1'b1, 3'b101, 1'b0);
      exp_sync(hs, 1'b0);
      expect_at(0, K_RGB, 2, 16'h0);
      exp_state(1'b0, 16'h0);
    end

    // First frame start enters RUN; the start-cycle pixel is still gated.
    step(1'b0, 1'b1, 1'b1, 3'b101, 1'b0);
    exp_sync(1'b0, 1'b1); exp_state(1'b1, 16'h1);
    expect_at(0, K_RGB, 2, 16'h0); expect_at(1, K_RGB, 4, 16'h0);
    step(1'b1, 1'b1, 1'b1, 3'b101, 1'b0);
    exp_sync(1'b1, 1'b1); exp_state(1'b1, 16'h1);
    expect_at(0, K_RGB, 2, 16'h5); expect_at(1, K_RGB, 4, 16'h5);
    step(1'b0, 1'b1, 1'b0, 3'b101, 1'b0);
    exp_sync(1'b0, 1'b1); expect_at(0, K_RGB, 2, 16'h0);
    step(1'b1, 1'b1, 1'b1, 3'b011, 1'b0);
    expect_at(0, K_RGB, 2, 16'h3); exp_state(1'b1, 16'h1);
    step(1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
    exp_sync(1'b0, 1'b0); expect_at(0, K_RGB, 2, 16'h6);

    // Mute raised mid-frame has no effect until the next frame start.
    step(1'b1, 1'b0, 1'b1, 3'b101, 1'b1);
    exp_sync(1'b1, 1'b0); expect_at(0, K_RGB, 2, 16'h5); exp_state(1'b1, 16'h1);
    step(1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
    expect_at(0, K_RGB, 2, 16'h5); exp_state(1'b1, 16'h1);
    step(1'b1, 1'b1, 1'b1, 3'b101, 1'b1);
    exp_sync(1'b1, 1'b1); expect_at(0, K_RGB, 2, 16'h5); exp_state(1'b0, 16'h2);
    step(1'b0, 1'b1, 1'b1, 3'b101, 1'b1);
    exp_sync(1'b0, 1'b1); expect_at(0, K_RGB, 2, 16'h0); exp_state(1'b0, 16'h2);
    // Mute dropped mid-frame: still muted until the next frame start.
    step(1'b1, 1'b0, 1'b1, 3'b101, 1'b0);
    exp_sync(1'b1, 1'b0); expect_at(0, K_RGB, 2, 16'h0); exp_state(1'b0, 16'h2);
    step(1'b0, 1'b0, 1'b1, 3'b101, 1'b0);
    expect_at(0, K_RGB, 2, 16'h0);
    step(1'b1, 1'b1, 1'b1, 3'b101, 1'b0);
    expect_at(0, K_RGB, 2, 16'h0); exp_state(1'b1, 16'h3);
    step(1'b0, 1'b1, 1'b1, 3'b101, 1'b0);
    expect_at(0, K_RGB, 2, 16'h5);
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Counter wrap, then a long vsync pulse counts once.
    @(negedge clk);
    force dut0.cnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut0.cnt_q;
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    exp_state(1'b1, 16'h0);
    for (int j = 0; j < 100; j++) begin
      step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      if (j == 50 || j == 99) expect_at(0, K_FC, 1, 16'h0);
    end
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    exp_state(1'b1, 16'h1);
    step(1'b0, 1'b0, 1'b1, 3'b101, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, 1'b1, 3'b101, 1'b0);
      expect_at(0, K_RGB, 2, 16'h5);
    end
    repeat (6) @(negedge clk);
    chk("pre_reset_rgb0", {13'd0, rgb0}, 16'h5);
    chk("pre_reset_queue_empty", 16'(sbq.size()), 16'h0);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    chk("async_rgb0",  {13'd0, rgb0}, 16'h0);
    chk("async_ov0",   {15'd0, ov0},  16'h0);
    chk("async_fc0",   fc0,           16'h0);
    chk("async_state", {14'd0, dut0.state_q}, {14'd0, SYNC_WAIT});
    chk("async_hs1",   {15'd0, hs1},  16'h1);
    chk("async_rgb1",  {13'd0, rgb1}, 16'h0);

    // vsync already high at release is not a frame start.
    vsync_i = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      exp_state(1'b0, 16'h0);
    end
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    exp_state(1'b1, 16'h1);

    for (int j = 0; j < 10 && sbq.size() != 0; j++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_out_stage.md
VGA_OUT_STAGE -- requirements
Module: vga_out_stage

Interface
REQ-001 The module SHALL have parameter PIPE_DEPTH, default 2, setting the pipeline latency in clk cycles; the legal range is 1..4.
REQ-002 The module SHALL have parameter OUT_INVERT, default 0; when 1, the hsync/vsync outputs are inverted for negative-polarity monitors.
REQ-003 The module SHALL have port clk, input, 1 bit: the single pixel clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port hsync_i, input, 1 bit: active-high horizontal sync from the timing generator.
REQ-006 The module SHALL have port vsync_i, input, 1 bit: active-high vertical sync from the timing generator.
REQ-007 The module SHALL have port display_on_i, input, 1 bit: visible-area flag.
REQ-008 The module SHALL have port rgb_i, input, 3 bits: pixel colour from the pattern stage, e.g. the starfield.
REQ-009 The module SHALL have port mute_req, input, 1 bit: level request to blank video, sampled only at frame start.
REQ-010 The module SHALL have port hsync, output, 1 bit: delayed hsync_i, XOR OUT_INVERT.
REQ-011 The module SHALL have port vsync, output, 1 bit: delayed vsync_i, XOR OUT_INVERT.
REQ-012 The module SHALL have port rgb, output, 3 bits: gated, delayed pixel colour.
REQ-013 The module SHALL have port frame_cnt, output, 16 bits: count of frame starts since reset.
REQ-014 The module SHALL have port out_valid, output, 1 bit: high while the FSM is in RUN.

Function
REQ-015 Frame start SHALL be the cycle in which vsync_i=1 and the registered previous vsync_i=0 (rising edge), detected with a one-flop history register.
REQ-016 The FSM SHALL have states SYNC_WAIT, RUN and MUTED, and SHALL change state only in a frame-start cycle.
REQ-017 SYNC_WAIT SHALL go to RUN at the first frame start if mute_req=0, and to MUTED if mute_req=1.
REQ-018 RUN SHALL go to MUTED at a frame start with mute_req=1; MUTED SHALL go to RUN at a frame start with mute_req=0; otherwise the state holds.
REQ-019 Stage-1 colour SHALL be rgb_i when (current state == RUN and display_on_i=1), else 3'b000; the state used is the registered value before that cycle's update.
REQ-020 hsync_i and vsync_i SHALL pass through in every state, including SYNC_WAIT, so the monitor can lock before video is enabled.
REQ-021 hsync, vsync and rgb SHALL each have a latency of exactly PIPE_DEPTH cycles from their inputs and SHALL stay mutually aligned.
REQ-022 frame_cnt SHALL increment by 1 in each frame-start cycle (visible on the next edge) and SHALL wrap from 16'hFFFF to 16'h0000 without flagging.
REQ-023 out_valid SHALL be a registered decode of state==RUN, with no extra delay relative to the state register.
REQ-024 mute_req changes between frame starts SHALL have no effect, so there is no mid-frame tearing.
REQ-025 vsync_i held high for many cycles SHALL produce exactly one frame start.
REQ-026 vsync_i high in the first cycle after reset release SHALL NOT count as a frame start, because the history register resets to 1.

Reset
REQ-027 While reset=0, the module SHALL hold: state=SYNC_WAIT, frame_cnt=0, out_valid=0, rgb=0, hsync=vsync=OUT_INVERT (inactive level), all pipeline stages at the inactive level, and the vsync history register at 1.
REQ-028 Reset assertion SHALL take effect immediately (asynchronously), including mid-frame or mid-pipeline; release SHALL be used only synchronised to clk by the system.

Structure
REQ-029 A shared package vga_out_pkg SHALL hold the FSM state typedef (2-bit encoding SYNC_WAIT=0, RUN=1, MUTED=2) and the PIPE_DEPTH default and maximum constants.
REQ-030 One sub-module, vga_delay_line (parameters WIDTH, DEPTH; async active-low reset to a parameter RESET_VAL), SHALL implement the 5-bit {hsync, vsync, rgb} pipeline and be instantiated once.

Verification
REQ-031 Reset, then toggle hsync_i with vsync_i=0 and rgb_i=3'b101, display_on_i=1 -> the hsync edges appear 2 cycles later, rgb=0, out_valid=0, frame_cnt=0.
REQ-032 First vsync_i rise with mute_req=0 -> out_valid=1 from the next cycle, frame_cnt=1, and the subsequent visible pixel rgb_i=3'b101 appears as rgb=3'b101 after 2 cycles.
REQ-033 mute_req=1 raised mid-frame -> rgb stays unchanged until the next vsync rise; after it, out_valid=0, rgb=0 and sync continues to toggle.
REQ-034 Force frame_cnt to 16'hFFFF, apply one vsync rise -> frame_cnt=16'h0000; a vsync_i held high for 100 cycles -> exactly one increment.
REQ-035 OUT_INVERT=1 and PIPE_DEPTH=4 -> hsync/vsync read 1 during reset and are inverted copies delayed by 4 cycles afterwards.
REQ-036 Assert reset asynchronously mid-line while rgb is nonzero -> rgb=0, state=SYNC_WAIT and frame_cnt=0 immediately, without waiting for a clk edge.
